// File: rtl/fmap_buf_pkg.sv
// Shared types and geometry for the feature-map buffer sequencer.
// Optional chip readback grant is enabled with FMAP_CHIP_RD_EN.
package fmap_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN,
    ST_FLUSH
  } fmap_state_t;

  localparam int FMAP_ROWS  = 28;
  localparam int FMAP_COLS  = 7;
  localparam int FMAP_LANES = 4;
  localparam int FMAP_BEATS = FMAP_ROWS * FMAP_COLS / FMAP_LANES;

endpackage

// File: rtl/fmap_lane_addr.sv
// Per-lane (row, col) addresses from a raster base, plus the next base.
// Columns wrap to 0 with a row increment; all lanes resolve in parallel.
module fmap_lane_addr #(
  parameter int COLS   = 7,
  parameter int LANES  = 4,
  parameter int AW_ROW = 5,
  parameter int AW_COL = 3
) (
  input  logic [AW_ROW-1:0]             base_row_i,
  input  logic [AW_COL-1:0]             base_col_i,
  output logic [LANES-1:0][AW_ROW-1:0]  row_o,
  output logic [LANES-1:0][AW_COL-1:0]  col_o,
  output logic [AW_ROW-1:0]             nxt_row_o,
  output logic [AW_COL-1:0]             nxt_col_o
);

  localparam int CW = AW_COL + 2;

  logic [LANES:0][CW-1:0] sum;

  // LANES never exceeds COLS, so at most one wrap per lane
  always_comb begin
    sum       = '0;
    row_o     = '0;
    col_o     = '0;
    nxt_row_o = base_row_i;
    nxt_col_o = base_col_i;
    for (int i = 0; i <= LANES; i++) begin
      sum[i] = CW'(base_col_i) + CW'(i);
    end
    for (int i = 0; i < LANES; i++) begin
      if (sum[i] >= CW'(COLS)) begin
        row_o[i] = base_row_i + 1'b1;
        col_o[i] = AW_COL'(sum[i] - CW'(COLS));
      end else begin
        row_o[i] = base_row_i;
        col_o[i] = AW_COL'(sum[i]);
      end
    end
    if (sum[LANES] >= CW'(COLS)) begin
      nxt_row_o = base_row_i + 1'b1;
      nxt_col_o = AW_COL'(sum[LANES] - CW'(COLS));
    end else begin
      nxt_col_o = AW_COL'(sum[LANES]);
    end
  end

endmodule

// File: rtl/fmap_buf_ctrl.sv
// Fill/drain sequencer for the 28x7 feature-map buffer.
// Define FMAP_CHIP_RD_EN to add the idle-time chip readback grant.
module fmap_buf_ctrl
  import fmap_buf_pkg::*;
#(
  parameter int DW     = 8,
  parameter int ROWS   = FMAP_ROWS,
  parameter int COLS   = FMAP_COLS,
  parameter int LANES  = FMAP_LANES,
  parameter int AW_ROW = 5,
  parameter int AW_COL = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                wr_en,
  output logic [AW_ROW-1:0]   wr_row0,
  output logic [AW_ROW-1:0]   wr_row1,
  output logic [AW_ROW-1:0]   wr_row2,
  output logic [AW_ROW-1:0]   wr_row3,
  output logic [AW_COL-1:0]   wr_col0,
  output logic [AW_COL-1:0]   wr_col1,
  output logic [AW_COL-1:0]   wr_col2,
  output logic [AW_COL-1:0]   wr_col3,
  output logic                rd_en,
  output logic [AW_ROW-1:0]   rd_row,
  input  logic [COLS*DW-1:0]  rd_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [COLS*DW-1:0]  out_data,
  output logic [AW_ROW-1:0]   out_row,
  output logic                done,
  output logic                busy
`ifdef FMAP_CHIP_RD_EN
  ,
  input  logic                chip_req,
  output logic                chip_gnt,
  output logic                chiprd_en
`endif
);

  localparam int BEATS = ROWS * COLS / LANES;
  localparam int BW    = $clog2(BEATS + 1);

  fmap_state_t               state_q, state_d;
  logic [BW-1:0]             b_q, b_d;
  logic [AW_ROW-1:0]         brow_q, brow_d;
  logic [AW_COL-1:0]         bcol_q, bcol_d;
  logic [AW_ROW-1:0]         r_q, r_d;
  logic                      ov_q, ov_d;
  logic [COLS*DW-1:0]        od_q, od_d;
  logic [AW_ROW-1:0]         orow_q, orow_d;
  logic                      done_q, done_d;

  logic [LANES-1:0][AW_ROW-1:0] lrow;
  logic [LANES-1:0][AW_COL-1:0] lcol;
  logic [AW_ROW-1:0]            nrow;
  logic [AW_COL-1:0]            ncol;
  logic                         fill;

  fmap_lane_addr #(
    .COLS   (COLS),
    .LANES  (LANES),
    .AW_ROW (AW_ROW),
    .AW_COL (AW_COL)
  ) u_lane_addr (
    .base_row_i (brow_q),
    .base_col_i (bcol_q),
    .row_o      (lrow),
    .col_o      (lcol),
    .nxt_row_o  (nrow),
    .nxt_col_o  (ncol)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      b_q     <= '0;
      brow_q  <= '0;
      bcol_q  <= '0;
      r_q     <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      orow_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      brow_q  <= brow_d;
      bcol_q  <= bcol_d;
      r_q     <= r_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      orow_q  <= orow_d;
      done_q  <= done_d;
    end
  end

  assign fill     = (state_q == ST_FILL);
  assign in_ready = fill;
  assign wr_en    = in_valid && fill;
  assign rd_en    = (state_q == ST_DRAIN);
  assign busy     = (state_q != ST_IDLE);

  // Addresses are forced to zero outside their phase
  assign wr_row0 = fill ? lrow[0] : '0;
  assign wr_row1 = fill ? lrow[1] : '0;
  assign wr_row2 = fill ? lrow[2] : '0;
  assign wr_row3 = fill ? lrow[3] : '0;
  assign wr_col0 = fill ? lcol[0] : '0;
  assign wr_col1 = fill ? lcol[1] : '0;
  assign wr_col2 = fill ? lcol[2] : '0;
  assign wr_col3 = fill ? lcol[3] : '0;
  assign rd_row  = rd_en ? r_q : '0;

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_row   = orow_q;
  assign done      = done_q;

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    brow_d  = brow_q;
    bcol_d  = bcol_q;
    r_d     = r_q;
    ov_d    = ov_q;
    od_d    = od_q;
    orow_d  = orow_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FILL;
          b_d     = '0;
          brow_d  = '0;
          bcol_d  = '0;
          r_d     = '0;
        end
      end
      ST_FILL: begin
        if (wr_en) begin
          b_d    = b_q + 1'b1;
          brow_d = nrow;
          bcol_d = ncol;
          if (b_q == BW'(BEATS - 1)) begin
            state_d = ST_DRAIN;
            r_d     = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (!ov_q || out_ready) begin
          od_d   = rd_data;
          orow_d = r_q;
          ov_d   = 1'b1;
          r_d    = r_q + 1'b1;
          if (r_q == AW_ROW'(ROWS - 1)) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (ov_q && out_ready) begin
          ov_d    = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef FMAP_CHIP_RD_EN
  assign chip_gnt  = (state_q == ST_IDLE) && chip_req && !start;
  assign chiprd_en = chip_gnt;
`endif

endmodule

// File: tb/tb_fmap_buf_ctrl.sv
// Self-checking bench for fmap_buf_ctrl with a behavioural buffer model.
// Chip readback checks are compiled in with FMAP_CHIP_RD_EN.
module tb_fmap_buf_ctrl;

  localparam int DW = 8, ROWS = 28, COLS = 7, NB = 49;

  logic clk = 1'b0;
  logic reset, start, in_valid, in_ready, wr_en;
  logic [4:0] wr_row0, wr_row1, wr_row2, wr_row3;
  logic [2:0] wr_col0, wr_col1, wr_col2, wr_col3;
  logic rd_en, out_valid, out_ready, done, busy;
  logic [4:0] rd_row, out_row;
  logic [COLS*DW-1:0] rd_data, out_data;
`ifdef FMAP_CHIP_RD_EN
  logic chip_req, chip_gnt, chiprd_en;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  fmap_buf_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en),
    .wr_row0(wr_row0), .wr_row1(wr_row1),
    .wr_row2(wr_row2), .wr_row3(wr_row3),
    .wr_col0(wr_col0), .wr_col1(wr_col1),
    .wr_col2(wr_col2), .wr_col3(wr_col3),
    .rd_en(rd_en), .rd_row(rd_row), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row),
    .done(done), .busy(busy)
`ifdef FMAP_CHIP_RD_EN
    , .chip_req(chip_req), .chip_gnt(chip_gnt),
    .chiprd_en(chiprd_en)
`endif
  );

  always #5 clk = ~clk;

  logic [3:0][4:0] wra_row;
  logic [3:0][2:0] wra_col;
  assign wra_row = {wr_row3, wr_row2, wr_row1, wr_row0};
  assign wra_col = {wr_col3, wr_col2, wr_col1, wr_col0};

  // Buffer model: lane i of beat b stores pixel value k = 4b+i
  logic [7:0] mem [ROWS][COLS];
  int tbb = 0;

  always @(posedge clk) begin
    if (!reset) begin
      if (start && !busy) tbb <= 0;
      else if (wr_en) begin
        for (int i = 0; i < 4; i++)
          if (wra_row[i] < 5'(ROWS) && wra_col[i] < 3'(COLS))
            mem[wra_row[i]][wra_col[i]] <= 8'(4 * tbb + i);
        tbb <= tbb + 1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_row < 5'(ROWS))
      for (int c = 0; c < COLS; c++)
        rd_data[(COLS-1-c)*DW +: DW] = mem[rd_row][c];
  end

  typedef struct {
    int beat;
    int r[4];
    int c[4];
  } addr_vec_t;

  addr_vec_t tbl [3];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [COLS*DW-1:0] row_val(input int r);
    logic [COLS*DW-1:0] v;
    for (int c = 0; c < COLS; c++) v[(COLS-1-c)*DW +: DW] = 8'(COLS * r + c);
    return v;
  endfunction

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, 64'({in_ready, wr_en, rd_en, out_valid, done, busy}), 64'(0));
    chk({nm, "_addr"}, 64'({wra_row, wra_col, rd_row, out_row}), 64'(0));
    chk({nm, "_data"}, 64'(out_data), 64'(0));
`ifdef FMAP_CHIP_RD_EN
    chk({nm, "_chip"}, 64'({chip_gnt, chiprd_en}), 64'(0));
`endif
  endtask

  task automatic fill(input bit gaps, input int target);
    int nb = 0;
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b0;
`ifdef FMAP_CHIP_RD_EN
    chip_req = 1'b1;
    #1 chk("chip_gnt_start", 64'(chip_gnt), 64'(0));
`endif
    for (int cyc = 0; cyc < 300 && nb < target; cyc++) begin
      @(negedge clk);
      start = (gaps && cyc == 10);
      in_valid = gaps ? (cyc % 3 != 2) : 1'b1;
`ifdef FMAP_CHIP_RD_EN
      chip_req = (cyc == 5);
`endif
      #1;
      if (cyc == 0) chk("in_ready_cycle1", 64'(in_ready), 64'(1));
      chk("wr_en_fill", 64'(wr_en), 64'(in_valid));
`ifdef FMAP_CHIP_RD_EN
      if (cyc == 5) chk("chip_gnt_fill", 64'(chip_gnt), 64'(0));
`endif
      if (wr_en) begin
        for (int i = 0; i < 4; i++) begin
          chk("lane_row", 64'(wra_row[i]), 64'((4 * nb + i) / COLS));
          chk("lane_col", 64'(wra_col[i]), 64'((4 * nb + i) % COLS));
        end
        for (int t = 0; t < 3; t++)
          if (tbl[t].beat == nb)
            for (int i = 0; i < 4; i++)
              chk("tbl_addr", 64'({wra_row[i], wra_col[i]}),
                  64'({5'(tbl[t].r[i]), 3'(tbl[t].c[i])}));
        nb++;
      end
    end
    start = 1'b0;
`ifdef FMAP_CHIP_RD_EN
    chip_req = 1'b0;
`endif
    chk("fill_beats", 64'(nb), 64'(target));
    if (target == NB) begin
      @(negedge clk);
      in_valid = 1'b1;
      #1;
      chk("drain_entry", 64'({rd_en, in_ready, wr_en, out_valid}), 64'(4'b1000));
    end
  endtask

  task automatic drain(input bit rnd);
    int exp_row = 0, ndone = 0, after = -1;
    int first27 = -1, done_cyc = -1;
    bit stall = 1'b0;
    logic [COLS*DW-1:0] pdata = '0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
`ifdef FMAP_CHIP_RD_EN
      chip_req = (cyc == 2);
`endif
      #1;
      if (cyc == 0) chk("first_out_valid", 64'(out_valid), 64'(1));
      chk("wr_en_drain", 64'(wr_en), 64'(0));
`ifdef FMAP_CHIP_RD_EN
      if (cyc == 2) chk("chip_gnt_drain", 64'(chip_gnt), 64'(0));
`endif
      if (stall) chk("stall_stable", 64'(out_data), 64'(pdata));
      if (out_valid) begin
        chk("out_row", 64'(out_row), 64'(exp_row));
        chk("out_data", 64'(out_data), 64'(row_val(exp_row)));
        if (out_row == 5'd27 && first27 < 0) first27 = cyc;
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
        if (after < 0) after = cyc;
      end
      stall = out_valid && !out_ready;
      pdata = out_data;
      if (out_valid && out_ready) exp_row++;
      if (after >= 0 && cyc >= after + 3) break;
    end
`ifdef FMAP_CHIP_RD_EN
    chip_req = 1'b0;
`endif
    out_ready = 1'b0;
    chk("rows_drained", 64'(exp_row), 64'(ROWS));
    chk("done_count", 64'(ndone), 64'(1));
    chk("idle_after", 64'({busy, out_valid}), 64'(0));
    if (!rnd) chk("done_timing", 64'(done_cyc - first27), 64'(1));
  endtask

  initial begin
    tbl[0] = '{0,  '{0, 0, 0, 0},     '{0, 1, 2, 3}};
    tbl[1] = '{1,  '{0, 0, 0, 1},     '{4, 5, 6, 0}};
    tbl[2] = '{48, '{27, 27, 27, 27}, '{3, 4, 5, 6}};
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
`ifdef FMAP_CHIP_RD_EN
    chip_req = 1'b0;
`endif
    @(negedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
`ifdef FMAP_CHIP_RD_EN
    chip_req = 1'b1;
    #1 chk("chip_gnt_idle", 64'({chip_gnt, chiprd_en}), 64'(2'b11));
    chip_req = 1'b0;
`endif

    fill(1'b0, NB);
    drain(1'b0);

    fill(1'b1, NB);
    drain(1'b1);

    fill(1'b0, 20);
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1 chk_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    fill(1'b0, NB);
    drain(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
